// File: rtl/audio_stream_transceiver.sv
// SPI-slave PCM receiver feeding a frame FIFO that is streamed to a DAC as I2S.
// Underrun/overrun are sticky until status_clr.
module audio_stream_transceiver #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BCLK_DIV   = 2
) (
    input  logic                                 input_clk,
    input  logic                                 reset,
    input  logic                                 spi_sclk,
    input  logic                                 spi_mosi,
    input  logic                                 spi_cs_n,
    input  logic                                 mute,
    input  logic                                 status_clr,
    output logic                                 i2s_mclk,
    output logic                                 i2s_bclk,
    output logic                                 i2s_ws,
    output logic                                 i2s_sd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 underrun,
    output logic                                 overrun
);

    localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned TX_W    = 2 * SLOT_W;
    localparam int unsigned K_W     = $clog2(TX_W);
    localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W;

    localparam logic [CNT_W-1:0] FrameCnt = CNT_W'(FRAME_W);
    localparam logic [LVL_W-1:0] LvlFull  = LVL_W'(FIFO_DEPTH);
    localparam logic [K_W-1:0]   KMax     = K_W'(TX_W - 1);
    localparam logic [K_W-1:0]   WsLo     = K_W'(SLOT_W - 1);
    localparam logic [K_W-1:0]   WsHi     = K_W'(TX_W - 2);
    localparam logic [DIV_W-1:0] DivMax   = DIV_W'(BCLK_DIV - 1);

    // ------------------------------------------------------------------
    // SPI input synchronizers
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic       sclk_prev_q;
    logic       sclk_s, mosi_s, cs_s, sclk_rise;

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // ------------------------------------------------------------------
    // SPI frame assembly
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               push;

    // A completed frame is pushed even if CS rises in the same cycle.
    assign push = (bit_cnt_q == FrameCnt);

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (push) begin
            bit_cnt_d = '0;
        end
        if (cs_s) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[FRAME_W-2:0], mosi_s};
            bit_cnt_d = push ? CNT_W'(1) : bit_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               fifo_empty, fifo_full, pop, push_ok, load;
    logic [FRAME_W-1:0] rd_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LvlFull);
    assign pop        = load & ~fifo_empty;
    // A concurrent pop frees the slot, so a push at full is only dropped without one.
    assign push_ok    = push & (~fifo_full | pop);
    assign rd_data    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // BCLK divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             div_wrap, fall_tick;

    assign div_wrap  = (div_q == DivMax);
    assign fall_tick = div_wrap & bclk_q;

    always_comb begin
        div_d  = div_wrap ? '0 : div_q + DIV_W'(1);
        bclk_d = div_wrap ? ~bclk_q : bclk_q;
    end

    // ------------------------------------------------------------------
    // I2S serializer
    // ------------------------------------------------------------------
    logic [K_W-1:0]      k_q, k_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic                ws_q, ws_d, sd_q, sd_d;
    logic [SAMPLE_W-1:0] sample_l, sample_r;
    logic [SLOT_W-1:0]   slot_l, slot_r;
    logic [TX_W-1:0]     frame_word;

    // With one channel both picks land on the same sample.
    assign sample_l = rd_data[FRAME_W-1 -: SAMPLE_W];
    assign sample_r = rd_data[SAMPLE_W-1:0];
    assign slot_l   = SLOT_W'(sample_l) << PAD_W;
    assign slot_r   = SLOT_W'(sample_r) << PAD_W;

    always_comb begin
        k_d        = k_q;
        tx_d       = tx_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        load       = 1'b0;
        frame_word = (mute | fifo_empty) ? '0 : {slot_l, slot_r};
        if (fall_tick) begin
            k_d  = (k_q == KMax) ? '0 : k_q + K_W'(1);
            load = (k_q == KMax);
            ws_d = (k_d >= WsLo) && (k_d <= WsHi);
            if (load) begin
                sd_d = frame_word[TX_W-1];
                tx_d = frame_word << 1;
            end else begin
                sd_d = tx_q[TX_W-1];
                tx_d = tx_q << 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status; a set event beats a simultaneous clear
    // ------------------------------------------------------------------
    logic underrun_q, underrun_d, overrun_q, overrun_d;

    always_comb begin
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        if (status_clr) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (load && fifo_empty) begin
            underrun_d = 1'b1;
        end
        if (push && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            k_q        <= KMax;
            tx_q       <= '0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            k_q        <= k_d;
            tx_q       <= tx_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign i2s_mclk   = input_clk;
    assign i2s_bclk   = bclk_q;
    assign i2s_ws     = ws_q;
    assign i2s_sd     = sd_q;
    assign fifo_level = count_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_stream_transceiver.sv
// Directed bench: default stereo path, a mono 24-bit variant, and a slow-BCLK
// variant whose long frames let the FIFO fill between loads.
module tb_audio_stream_transceiver;

    logic clk = 1'b0;
    logic rst_n, sclk, mosi, cs_n, mute, clr;
    logic mclk0, bclk0, ws0, sd0, ur0, or0;
    logic mclk1, bclk1, ws1, sd1, ur1, or1;
    logic mclk2, bclk2, ws2, sd2, ur2, or2;
    logic [3:0] lvl0, lvl1, lvl2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_stream_transceiver dut0 (
        .input_clk(clk), .reset(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n),
        .mute(mute), .status_clr(clr), .i2s_mclk(mclk0), .i2s_bclk(bclk0), .i2s_ws(ws0),
        .i2s_sd(sd0), .fifo_level(lvl0), .underrun(ur0), .overrun(or0)
    );

    audio_stream_transceiver #(.SAMPLE_W(24), .CHANNELS(1)) dut1 (
        .input_clk(clk), .reset(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n),
        .mute(mute), .status_clr(clr), .i2s_mclk(mclk1), .i2s_bclk(bclk1), .i2s_ws(ws1),
        .i2s_sd(sd1), .fifo_level(lvl1), .underrun(ur1), .overrun(or1)
    );

    audio_stream_transceiver #(.BCLK_DIV(32)) dut2 (
        .input_clk(clk), .reset(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n),
        .mute(mute), .status_clr(clr), .i2s_mclk(mclk2), .i2s_bclk(bclk2), .i2s_ws(ws2),
        .i2s_sd(sd2), .fifo_level(lvl2), .underrun(ur2), .overrun(or2)
    );

    function automatic logic get_bclk(input int sel);
        return (sel == 0) ? bclk0 : (sel == 1) ? bclk1 : bclk2;
    endfunction

    function automatic logic get_ws(input int sel);
        return (sel == 0) ? ws0 : (sel == 1) ? ws1 : ws2;
    endfunction

    function automatic logic get_sd(input int sel);
        return (sel == 0) ? sd0 : (sel == 1) ? sd1 : sd2;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; mute = 1'b0; clr = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic spi_begin();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Returns at the first negedge after a rising edge of the selected BCLK.
    task automatic wait_rise(input int sel, output bit ok);
        logic pb;
        int   n;
        ok = 1'b0;
        pb = get_bclk(sel);
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (get_bclk(sel) && !pb) ok = 1'b1;
            pb = get_bclk(sel);
        end
    endtask

    // Returns at the BCLK rise where WS falls, i.e. the last bit slot of a frame.
    task automatic sync_frame(input int sel, output bit ok);
        logic pw;
        int   n;
        bit   found;
        found = 1'b0;
        ok    = 1'b1;
        pw    = 1'b0;
        n     = 0;
        while (ok && !found && n < 200) begin
            wait_rise(sel, ok);
            if (ok && pw && !get_ws(sel)) found = 1'b1;
            pw = get_ws(sel);
            n++;
        end
        if (!found) begin
            ok = 1'b0;
            checks++;
            errors++;
            $display("FAIL sync_timeout sel=%0d", sel);
        end
    endtask

    // Captures the 64 BCLK slots of one frame, slot 0 in bit 63.
    task automatic capture(input int sel, input bit sync, output logic [63:0] sdw,
                           output logic [63:0] wsw);
        bit ok;
        sdw = '0;
        wsw = '0;
        ok  = 1'b1;
        if (sync) sync_frame(sel, ok);
        for (int i = 0; i < 64 && ok; i++) begin
            wait_rise(sel, ok);
            sdw = {sdw[62:0], get_sd(sel)};
            wsw = {wsw[62:0], get_ws(sel)};
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout sel=%0d", sel);
        end
    endtask

    task automatic test_reset();
        logic [63:0] sdw, wsw;
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; mute = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bclk0, ws0, sd0, ur0, or0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", {bclk0, ws0, sd0, ur0, or0});
        end
        checks++;
        if (lvl0 !== 4'd0 || lvl2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_level got %0d/%0d exp 0/0", lvl0, lvl2);
        end
        checks++;
        if (mclk0 !== clk) begin
            errors++;
            $display("FAIL mclk got %b exp %b", mclk0, clk);
        end
        rst_n = 1'b1;
        // Expected BCLK per negedge after release: 0 1 1 0 0 1
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (bclk0 !== ((c == 2 || c == 3 || c == 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL bclk_phase cycle=%0d got %b", c, bclk0);
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (ur0 !== (c == 4)) begin
                    errors++;
                    $display("FAIL first_underrun cycle=%0d got %b exp %b", c, ur0, c == 4);
                end
            end
        end
        capture(0, 1'b1, sdw, wsw);
        checks++;
        if (wsw !== 64'h0000_0001_FFFF_FFFE) begin
            errors++;
            $display("FAIL idle_ws got %h exp 00000001fffffffe", wsw);
        end
        checks++;
        if (sdw !== 64'h0) begin
            errors++;
            $display("FAIL idle_sd got %h exp 0", sdw);
        end
    endtask

    task automatic test_frame();
        logic [63:0] sdw, wsw;
        bit ok;
        do_reset();
        sync_frame(0, ok);
        checks++;
        if (lvl0 !== 4'd0) begin
            errors++;
            $display("FAIL frame_level_pre got %0d exp 0", lvl0);
        end
        repeat (80) @(negedge clk);
        spi_begin();
        spi_bits(32'hA5A5_3C3C, 32);
        spi_end();
        checks++;
        if (lvl0 !== 4'd1) begin
            errors++;
            $display("FAIL frame_level_push got %0d exp 1", lvl0);
        end
        capture(0, 1'b1, sdw, wsw);
        checks++;
        if (sdw !== 64'hA5A5_0000_3C3C_0000) begin
            errors++;
            $display("FAIL frame_sd got %h exp a5a500003c3c0000", sdw);
        end
        checks++;
        if (wsw !== 64'h0000_0001_FFFF_FFFE) begin
            errors++;
            $display("FAIL frame_ws got %h exp 00000001fffffffe", wsw);
        end
        checks++;
        if (lvl0 !== 4'd0 || or0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_level_pop got lvl=%0d ovr=%b exp 0/0", lvl0, or0);
        end
    endtask

    task automatic test_cs_abort();
        logic [63:0] sdw, wsw;
        bit ok;
        do_reset();
        sync_frame(0, ok);
        repeat (20) @(negedge clk);
        spi_begin();
        spi_bits(32'h000F_FFFF, 20);
        spi_end();
        checks++;
        if (lvl0 !== 4'd0) begin
            errors++;
            $display("FAIL abort_partial_level got %0d exp 0", lvl0);
        end
        sync_frame(0, ok);
        repeat (80) @(negedge clk);
        spi_begin();
        spi_bits(32'h1234_5678, 32);
        spi_end();
        checks++;
        if (lvl0 !== 4'd1) begin
            errors++;
            $display("FAIL abort_level got %0d exp 1", lvl0);
        end
        capture(0, 1'b1, sdw, wsw);
        checks++;
        if (sdw !== 64'h1234_0000_5678_0000) begin
            errors++;
            $display("FAIL abort_sd got %h exp 1234000056780000", sdw);
        end
    endtask

    task automatic test_mono();
        logic [63:0] sdw, wsw;
        bit ok;
        do_reset();
        sync_frame(1, ok);
        repeat (80) @(negedge clk);
        spi_begin();
        spi_bits(32'h0080_0001, 24);
        spi_end();
        checks++;
        if (lvl1 !== 4'd1) begin
            errors++;
            $display("FAIL mono_level got %0d exp 1", lvl1);
        end
        capture(1, 1'b1, sdw, wsw);
        checks++;
        if (sdw !== 64'h8000_0100_8000_0100) begin
            errors++;
            $display("FAIL mono_sd got %h exp 8000010080000100", sdw);
        end
    endtask

    task automatic test_mute();
        logic [63:0] sdw, wsw;
        bit ok;
        do_reset();
        repeat (100) @(negedge clk);
        spi_begin();
        spi_bits(32'hFFFF_FFFF, 32);
        spi_bits(32'h8001_8001, 32);
        spi_end();
        pulse_clr();
        checks++;
        if (lvl2 !== 4'd2 || ur2 !== 1'b0) begin
            errors++;
            $display("FAIL mute_pre got lvl=%0d ur=%b exp 2/0", lvl2, ur2);
        end
        mute = 1'b1;
        for (int f = 0; f < 2; f++) begin
            capture(2, f == 0, sdw, wsw);
            checks++;
            if (sdw !== 64'h0) begin
                errors++;
                $display("FAIL mute_sd frame=%0d got %h exp 0", f, sdw);
            end
            checks++;
            if (lvl2 !== 4'(1 - f) || ur2 !== 1'b0) begin
                errors++;
                $display("FAIL mute_level frame=%0d got lvl=%0d ur=%b exp %0d/0",
                         f, lvl2, ur2, 1 - f);
            end
        end
        wait_rise(2, ok);
        checks++;
        if (ur2 !== 1'b1) begin
            errors++;
            $display("FAIL mute_underrun got %b exp 1", ur2);
        end
        mute = 1'b0;
    endtask

    task automatic test_overrun();
        logic [63:0] sdw, wsw;
        logic [31:0] f;
        do_reset();
        repeat (100) @(negedge clk);
        spi_begin();
        for (int i = 0; i < 9; i++) begin
            f = 32'(32'h1111_1111 * (i + 1));
            spi_bits(f, 32);
        end
        spi_end();
        checks++;
        if (lvl2 !== 4'd8 || or2 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_full got lvl=%0d ovr=%b exp 8/1", lvl2, or2);
        end
        pulse_clr();
        checks++;
        if (or2 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr got %b exp 0", or2);
        end
        for (int i = 0; i < 9; i++) begin
            f = (i < 8) ? 32'(32'h1111_1111 * (i + 1)) : 32'h0;
            capture(2, i == 0, sdw, wsw);
            checks++;
            if (sdw !== {f[31:16], 16'h0, f[15:0], 16'h0}) begin
                errors++;
                $display("FAIL overrun_drain frame=%0d got %h exp %h", i, sdw,
                         {f[31:16], 16'h0, f[15:0], 16'h0});
            end
        end
        checks++;
        if (lvl2 !== 4'd0 || ur2 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_end got lvl=%0d ur=%b exp 0/1", lvl2, ur2);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        repeat (100) @(negedge clk);
        spi_begin();
        spi_bits(32'hCAFE_F00D, 32);
        spi_bits(32'h0000_FFFF, 16);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (lvl2 !== 4'd0 || ur2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got lvl=%0d ur=%b exp 0/0", lvl2, ur2);
        end
        rst_n = 1'b1;
        cs_n  = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_cs_abort();
        test_mono();
        test_mute();
        test_overrun();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_stream_transceiver.md
Name: audio_stream_transceiver

Overview:
- Parametrised SPI-in / I2S-out audio path with multi-channel framing, a sample FIFO, mute, and underrun/overrun status.
- Receives PCM frames from a host over an SPI slave link, buffers whole frames in a FIFO, and streams them to the DAC as standard I2S at a BCLK rate set by a divider.
- Replaces the fixed 16-bit mono, unbuffered transceiver path at the top of the audio design.

Parameters:
- SAMPLE_W, 16, bits per channel sample (8..32).
- SLOT_W, 32, I2S bits per channel slot; must be >= SAMPLE_W.
- CHANNELS, 2, channels per frame (1 or 2); left is first.
- FIFO_DEPTH, 8, frame entries; power of two, >= 2.
- BCLK_DIV, 2, input_clk cycles per BCLK half-period (2 gives 3.072 MHz from 12.288 MHz).

Ports:
- input_clk  in  1  system clock, also the DAC MCLK.
- reset  in  1  asynchronous, active-low.
- spi_sclk  in  1  SPI clock, asynchronous; must be <= input_clk/8.
- spi_mosi  in  1  SPI data, mode 0, MSB first.
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
- mute  in  1  forces transmitted samples to zero.
- status_clr  in  1  single-cycle pulse that clears the sticky flags.
- i2s_mclk  out  1  equals input_clk (combinational).
- i2s_bclk  out  1  bit clock.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- i2s_sd  out  1  serial data.
- fifo_level  out  clog2(FIFO_DEPTH+1)  number of frames stored.
- underrun  out  1  sticky: a frame was needed while the FIFO was empty.
- overrun  out  1  sticky: a frame was received while the FIFO was full.

Behaviour:
- Reset (asynchronous): i2s_bclk=0, i2s_ws=0, i2s_sd=0, FIFO empty, fifo_level=0, underrun=0, overrun=0, SPI bit counter=0, I2S bit index k=2*SLOT_W-1, BCLK divider count=0.

SPI receive:
- spi_sclk, spi_mosi and spi_cs_n each pass through a 2-FF synchronizer into input_clk.
- A rising edge of synchronized sclk while synchronized cs_n=0 shifts mosi into a FRAME_W=CHANNELS*SAMPLE_W register and increments the bit counter.
- When the counter reaches FRAME_W, the frame is pushed to the FIFO on the next cycle and the counter returns to 0. Back-to-back frames within one CS assertion are allowed.
- cs_n rising: any partial frame is discarded and the counter cleared.
- Push while full: the frame is dropped, FIFO contents are unchanged, and overrun is set.

BCLK generator:
- The divider counts 0..BCLK_DIV-1; i2s_bclk toggles on wrap.
- First rising edge of i2s_bclk occurs BCLK_DIV cycles after reset release.
- All I2S outputs update only in the cycle i2s_bclk goes 1->0 (the "fall tick").

I2S transmit, per fall tick:
- k <= (k==2*SLOT_W-1) ? 0 : k+1.
- When k becomes 0, frame load:
  - If FIFO is non-empty: pop; slot L = channel 0; slot R = channel 1, or channel 0 again when CHANNELS=1.
  - If FIFO is empty: both slots are zero and underrun is set.
  - If mute=1 at this tick: both slots are zero, but a pop still occurs when data is available.
  - Each slot is the sample MSB-aligned, zero-padded to SLOT_W.
- i2s_ws = 1 for k in [SLOT_W-1, 2*SLOT_W-2], else 0. WS therefore leads the MSB by one BCLK, per the I2S standard.
- i2s_sd = bit (2*SLOT_W-1-k) of {slotL, slotR}. SD is held between ticks.
- Frame rate = input_clk / (4*BCLK_DIV*SLOT_W); defaults give 48 kHz.

FIFO and status:
- Simultaneous push and pop in the same cycle: both take effect and fifo_level is unchanged.
- A pop at full and a push at empty are handled correctly.
- Pointers wrap modulo FIFO_DEPTH.
- status_clr clears both flags. If a set event occurs in the same cycle, set wins.
- Reset asserted mid-frame aborts everything immediately; the partial SPI frame and the FIFO contents are lost.

Test Plan:
- Reset, FIFO empty, defaults: first 64 BCLKs show WS low for BCLK 0-30, high for 31-62, low at 63; SD all 0; underrun=1 after the first fall tick; bclk period = 4 input_clk cycles.
- SPI frame 0xA5A5_3C3C (L=0xA5A5, R=0x3C3C): fifo_level goes 0->1, then 1->0 at the next frame load. SD shows 1010010110100101 in BCLKs 0-15, zeros in 16-31, and 0011110000111100 in BCLKs 32-47.
- Nine frames pushed with FIFO_DEPTH=8 and no pops: fifo_level=8, overrun=1, and the ninth frame is absent from the output sequence. status_clr -> overrun=0.
- CS deasserted after 20 of 32 bits, then a full frame 0x1234_5678: only 0x1234/0x5678 is transmitted; fifo_level peaks at 1.
- mute=1 with 2 frames queued: SD is all zero and fifo_level decrements 2->1->0 at successive frame loads; underrun remains 0 until the FIFO is empty.
- CHANNELS=1, SAMPLE_W=24: SPI 0x800001 appears in both the L and R slots as MSB-first 24 bits followed by 8 zero pad bits.
